// File: rtl/patdata_fifo.sv
// DEPTH-entry pattern word queue feeding the blitter pattern mux, with sticky overflow.
// Optional nibble (4-bit pixel) presentation is compiled in with PATDATA_NIBBLE_EN.
module patdata_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     MasterClock,
  input  logic                     RESETL,
  input  logic                     LDPATL,
  input  logic [WIDTH-1:0]         ID,
  input  logic                     PATNXT,
  input  logic                     CLRPAT,
`ifdef PATDATA_NIBBLE_EN
  input  logic                     NIBMODE,
`endif
  output logic [WIDTH-1:0]         PATD,
  output logic                     PATVALID,
  output logic                     PATFULL,
  output logic                     PATOVF,
  output logic [$clog2(DEPTH):0]   PATCNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HALF  = WIDTH / 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  // Formats a stored word for the pixel path: whole word, or a replicated half.
  function automatic logic [WIDTH-1:0] present(input logic [WIDTH-1:0] word,
                                               input logic nib, input logic sub);
    logic [WIDTH-1:0] res;
    if (!nib) begin
      res = word;
    end else if (!sub) begin
      res = {word[HALF-1:0], word[HALF-1:0]};
    end else begin
      res = {word[WIDTH-1:HALF], word[WIDTH-1:HALF]};
    end
    return res;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_r, rd_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] patd_r;
  logic             valid_r, full_r, ovf_r;
`ifdef PATDATA_NIBBLE_EN
  logic             sub_r, nib_prev_r;
`endif

  logic             nib_s, sub_s, hold_s, adv_s, pop_s, push_s, rej_s, sub_nxt_s;
  logic             full_s, valid_s;
  logic [PTR_W-1:0] rd_nxt_s, wr_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] head_s, patd_nxt_s;

  // Next-state decode: push/pop arbitration, pointer/count updates, next PATD.
  always_comb begin
    nib_s  = 1'b0;
    sub_s  = 1'b0;
    hold_s = 1'b0;
`ifdef PATDATA_NIBBLE_EN
    nib_s  = NIBMODE;
    sub_s  = sub_r;
    hold_s = (NIBMODE != nib_prev_r);
`endif
    full_s    = (count_r == FULL_CNT);
    valid_s   = (count_r != ZERO_CNT);
    adv_s     = PATNXT && valid_s && !hold_s;
    pop_s     = adv_s && (!nib_s || sub_s);
    push_s    = !LDPATL && (!full_s || pop_s);
    rej_s     = !LDPATL && full_s && !pop_s;
    sub_nxt_s = adv_s && nib_s && !sub_s;
    if (hold_s) begin
      sub_nxt_s = 1'b0;
    end else if (!adv_s) begin
      sub_nxt_s = sub_s;
    end else begin
      sub_nxt_s = nib_s && !sub_s;
    end
    rd_nxt_s  = pop_s  ? rd_r + PTR_W'(1) : rd_r;
    wr_nxt_s  = push_s ? wr_r + PTR_W'(1) : wr_r;
    cnt_nxt_s = count_r + (push_s ? CNT_W'(1) : ZERO_CNT) - (pop_s ? CNT_W'(1) : ZERO_CNT);
    // The freshly pushed word is not in storage yet when it becomes the new head.
    if (push_s && (wr_r == rd_nxt_s)) begin
      head_s = ID;
    end else begin
      head_s = mem_r[rd_nxt_s];
    end
    if (cnt_nxt_s != ZERO_CNT) begin
      patd_nxt_s = present(head_s, nib_s, sub_nxt_s);
    end else begin
      patd_nxt_s = patd_r;
    end
  end

  // Queue state, storage and registered outputs; CLRPAT flushes but keeps PATD.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_r    <= {PTR_W{1'b0}};
      rd_r    <= {PTR_W{1'b0}};
      count_r <= ZERO_CNT;
      patd_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
`ifdef PATDATA_NIBBLE_EN
      sub_r      <= 1'b0;
      nib_prev_r <= 1'b0;
`endif
    end else if (CLRPAT) begin
      wr_r    <= {PTR_W{1'b0}};
      rd_r    <= {PTR_W{1'b0}};
      count_r <= ZERO_CNT;
      valid_r <= 1'b0;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
`ifdef PATDATA_NIBBLE_EN
      sub_r      <= 1'b0;
      nib_prev_r <= NIBMODE;
`endif
    end else begin
      if (push_s) begin
        mem_r[wr_r] <= ID;
      end
      wr_r    <= wr_nxt_s;
      rd_r    <= rd_nxt_s;
      count_r <= cnt_nxt_s;
      patd_r  <= patd_nxt_s;
      valid_r <= (cnt_nxt_s != ZERO_CNT);
      full_r  <= (cnt_nxt_s == FULL_CNT);
      ovf_r   <= ovf_r | rej_s;
`ifdef PATDATA_NIBBLE_EN
      sub_r      <= sub_nxt_s;
      nib_prev_r <= NIBMODE;
`endif
    end
  end

  assign PATD     = patd_r;
  assign PATVALID = valid_r;
  assign PATFULL  = full_r;
  assign PATOVF   = ovf_r;
  assign PATCNT   = count_r;

endmodule

// File: tb/tb_patdata_fifo.sv
// Self-checking bench for patdata_fifo (WIDTH=8, DEPTH=4) against a queue-based model.
module tb_patdata_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             MasterClock;
  logic             RESETL;
  logic             LDPATL;
  logic [WIDTH-1:0] ID;
  logic             PATNXT;
  logic             CLRPAT;
`ifdef PATDATA_NIBBLE_EN
  logic             NIBMODE;
`endif
  logic [WIDTH-1:0] PATD;
  logic             PATVALID, PATFULL, PATOVF;
  logic [2:0]       PATCNT;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] m_patd;
  logic             m_ovf;

  patdata_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .MasterClock(MasterClock),
    .RESETL(RESETL),
    .LDPATL(LDPATL),
    .ID(ID),
    .PATNXT(PATNXT),
    .CLRPAT(CLRPAT),
`ifdef PATDATA_NIBBLE_EN
    .NIBMODE(NIBMODE),
`endif
    .PATD(PATD),
    .PATVALID(PATVALID),
    .PATFULL(PATFULL),
    .PATOVF(PATOVF),
    .PATCNT(PATCNT)
  );

  initial begin
    MasterClock = 1'b0;
    forever #5 MasterClock = ~MasterClock;
  end

  // Expected output bundle {PATD, PATVALID, PATFULL, PATOVF, PATCNT} from the model.
  function automatic logic [13:0] exp_vec();
    return {m_patd, model_q.size() != 0, model_q.size() == DEPTH, m_ovf, 3'(model_q.size())};
  endfunction

  // Apply the queue rules to the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit full, pop;
    full = (model_q.size() == DEPTH);
    pop  = PATNXT && (model_q.size() != 0);
    if (CLRPAT) begin
      model_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (!LDPATL) begin
        if (!full || pop) model_q.push_back(ID);
        else m_ovf = 1'b1;
      end
      if (model_q.size() != 0) m_patd = model_q[0];
    end
    @(posedge MasterClock);
    #1;
  endtask

  task automatic idle_inputs();
    LDPATL = 1'b1; PATNXT = 1'b0; CLRPAT = 1'b0; ID = 8'h00;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h5A; vals[1] = 8'h6B; vals[2] = 8'h7C;
    idle_inputs();
    RESETL = 1'b0;
    model_q.delete(); m_ovf = 1'b0; m_patd = 8'h00;
    #12;
    n_cmp++;
    if ({PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== 14'h0) begin
      n_bad++; $display("FAIL reset_initial: got %h expected %h", {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, 14'h0);
    end
    RESETL = 1'b1;
    @(posedge MasterClock); #1;
    for (int i = 0; i < 3; i++) begin
      LDPATL = 1'b0; ID = vals[i];
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (PATCNT !== 3'd3 || PATD !== 8'h5A) begin
      n_bad++; $display("FAIL reset_preload: got cnt=%0d patd=%h expected cnt=3 patd=5a", PATCNT, PATD);
    end
    #1 RESETL = 1'b0;
    model_q.delete(); m_ovf = 1'b0; m_patd = 8'h00;
    #1;
    n_cmp++;
    if ({PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== 14'h0) begin
      n_bad++; $display("FAIL reset_async: got %h expected %h", {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, 14'h0);
    end
    #1 RESETL = 1'b1;
    LDPATL = 1'b0; ID = 8'h11;
    tick();
    idle_inputs();
    n_cmp++;
    if (PATD !== 8'h11 || PATCNT !== 3'd1 || {PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
      n_bad++; $display("FAIL reset_first_load: got patd=%h cnt=%0d expected patd=11 cnt=1", PATD, PATCNT);
    end
  endtask

  task automatic test_fill_overflow();
    CLRPAT = 1'b1; tick(); CLRPAT = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      LDPATL = 1'b0; ID = 8'(i);
      tick();
      n_cmp++;
      if ({PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
        n_bad++; $display("FAIL fill_step%0d: got %h expected %h", i, {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, exp_vec());
      end
    end
    n_cmp++;
    if (PATFULL !== 1'b1 || PATCNT !== 3'd4) begin
      n_bad++; $display("FAIL fill_full: got full=%b cnt=%0d expected full=1 cnt=4", PATFULL, PATCNT);
    end
    ID = 8'hFF;
    tick();
    n_cmp++;
    if (PATOVF !== 1'b1 || PATCNT !== 3'd4 || PATD !== 8'h01) begin
      n_bad++; $display("FAIL overflow: got ovf=%b cnt=%0d patd=%h expected ovf=1 cnt=4 patd=01", PATOVF, PATCNT, PATD);
    end
    LDPATL = 1'b1; PATNXT = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (PATD !== 8'(i <= 4 ? i : 4) || {PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
        n_bad++; $display("FAIL drain_pop%0d: got %h expected %h", i - 1, {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, exp_vec());
      end
    end
    tick();
    n_cmp++;
    if (PATD !== 8'h04 || PATVALID !== 1'b0) begin
      n_bad++; $display("FAIL empty_hold: got patd=%h valid=%b expected patd=04 valid=0", PATD, PATVALID);
    end
    idle_inputs();
  endtask

  task automatic test_simul_full();
    CLRPAT = 1'b1; tick(); CLRPAT = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      LDPATL = 1'b0; ID = 8'(i); tick();
    end
    ID = 8'hAA; PATNXT = 1'b1;
    tick();
    n_cmp++;
    if (PATCNT !== 3'd4 || PATOVF !== 1'b0 || PATD !== 8'h02) begin
      n_bad++; $display("FAIL simul_full: got cnt=%0d ovf=%b patd=%h expected cnt=4 ovf=0 patd=02", PATCNT, PATOVF, PATD);
    end
    LDPATL = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (PATD !== 8'hAA || PATCNT !== 3'd1 || {PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
      n_bad++; $display("FAIL simul_order: got patd=%h cnt=%0d expected patd=aa cnt=1", PATD, PATCNT);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      LDPATL = 1'b0; ID = 8'(8'h40 + i); tick();
    end
    n_cmp++;
    if (PATOVF !== 1'b1) begin
      n_bad++; $display("FAIL flush_setup_ovf: got %b expected 1", PATOVF);
    end
    LDPATL = 1'b0; PATNXT = 1'b1; CLRPAT = 1'b1; ID = 8'h99;
    tick();
    idle_inputs();
    n_cmp++;
    if (PATCNT !== 3'd0 || PATOVF !== 1'b0 || PATVALID !== 1'b0 || {PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
      n_bad++; $display("FAIL flush: got %h expected %h", {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int next_out;
    next_out = 0;
    LDPATL = 1'b0; ID = 8'd0; tick();
    ID = 8'd1; tick();
    for (int c = 0; c < 10; c++) begin
      LDPATL = (c < 8) ? 1'b0 : 1'b1;
      ID     = 8'(c + 2);
      PATNXT = 1'b1;
      n_cmp++;
      if (PATD !== 8'(next_out)) begin
        n_bad++; $display("FAIL wrap_order%0d: got %h expected %h", c, PATD, 8'(next_out));
      end
      next_out++;
      tick();
      n_cmp++;
      if (PATCNT > 3'd2 || {PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
        n_bad++; $display("FAIL wrap_state%0d: got %h expected %h", c, {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    CLRPAT = 1'b1; tick();
    for (int c = 0; c < 400; c++) begin
      LDPATL = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
      PATNXT = ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0;
      CLRPAT = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
      ID     = 8'($urandom);
      tick();
      n_cmp++;
      if ({PATD, PATVALID, PATFULL, PATOVF, PATCNT} !== exp_vec()) begin
        n_bad++; $display("FAIL random%0d: got %h expected %h", c, {PATD, PATVALID, PATFULL, PATOVF, PATCNT}, exp_vec());
      end
    end
    idle_inputs();
  endtask

`ifdef PATDATA_NIBBLE_EN
  task automatic test_nibble();
    CLRPAT = 1'b1; tick(); CLRPAT = 1'b0;
    NIBMODE = 1'b1;
    @(posedge MasterClock); #1;
    LDPATL = 1'b0; ID = 8'h3C;
    @(posedge MasterClock); #1;
    LDPATL = 1'b1;
    n_cmp++;
    if (PATD !== 8'hCC || PATCNT !== 3'd1) begin
      n_bad++; $display("FAIL nib_low: got patd=%h cnt=%0d expected patd=cc cnt=1", PATD, PATCNT);
    end
    PATNXT = 1'b1;
    @(posedge MasterClock); #1;
    n_cmp++;
    if (PATD !== 8'h33 || PATCNT !== 3'd1) begin
      n_bad++; $display("FAIL nib_high: got patd=%h cnt=%0d expected patd=33 cnt=1", PATD, PATCNT);
    end
    @(posedge MasterClock); #1;
    PATNXT = 1'b0;
    n_cmp++;
    if (PATCNT !== 3'd0 || PATVALID !== 1'b0) begin
      n_bad++; $display("FAIL nib_pop: got cnt=%0d valid=%b expected cnt=0 valid=0", PATCNT, PATVALID);
    end
    NIBMODE = 1'b0;
    @(posedge MasterClock); #1;
    model_q.delete(); m_ovf = 1'b0; m_patd = 8'h33;
  endtask
`endif

  initial begin
`ifdef PATDATA_NIBBLE_EN
    NIBMODE = 1'b0;
`endif
    test_reset();
    test_fill_overflow();
    test_simul_full();
    test_flush();
    test_back_to_back();
`ifdef PATDATA_NIBBLE_EN
    test_nibble();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/patdata_fifo.md
# patdata_fifo

Parametrised successor to the blitter's pattern data register. It replaces the single-entry transparent pattern latch with a DEPTH-entry, WIDTH-bit queue. The CPU/DMA side can preload several pattern words, and the blitter pixel path consumes them one per advance strobe. It sits between the internal data bus (ID) and the blitter source/pattern mux, and adds overflow reporting and an optional nibble (4-bit pixel) mode.

## Interface
Parameters:
- WIDTH, 8: pattern word width in bits; must be even.
- DEPTH, 4: queue entries; power of two, at least 2.

Ports:
- MasterClock  in  1  system clock; all state changes on its rising edge.
- RESETL  in  1  reset. One clock; reset is asynchronous and active-low.
- LDPATL  in  1  active-low load strobe, sampled synchronously; pushes ID.
- ID  in  WIDTH  internal data bus.
- PATNXT  in  1  active-high advance; consumes the current pixel or word.
- CLRPAT  in  1  synchronous flush of the queue and the overflow flag.
- NIBMODE  in  1  selects nibble mode; present only with PATDATA_NIBBLE_EN.
- PATD  out  WIDTH  current pattern output, registered.
- PATVALID  out  1  queue holds at least one entry.
- PATFULL  out  1  queue holds DEPTH entries.
- PATOVF  out  1  sticky overflow flag.
- PATCNT  out  $clog2(DEPTH)+1  current entry count.

## Operation
- Storage: circular buffer with write pointer, read pointer and count register. Pointers wrap modulo DEPTH.
- Push: occurs when LDPATL=0 and the queue is not full, or when it is full and a pop happens in the same cycle.
- Rejected push: LDPATL=0 while full with no pop. The data is dropped, PATOVF is set to 1 and the queue is unchanged.
- Pop: occurs when PATNXT=1, PATVALID=1 and the pixel sub-phase is complete (see nibble mode). PATNXT while empty is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push while empty with PATNXT=1: the push proceeds and PATNXT is ignored.
- CLRPAT=1 has priority over push and pop. It zeroes pointers, count, sub-phase and PATOVF. PATD holds its value.
- PATD is updated whenever the head entry or sub-phase changes. When empty, PATD holds the last presented value, matching old latch-hold behaviour. A push into an empty queue loads PATD directly from ID.
- Word mode (NIBMODE=0 or macro absent): PATD = head entry. Each PATNXT pops one entry.
- Nibble mode (NIBMODE=1): each entry supplies two pixels.
  - Sub-phase 0: PATD = {low half, low half}.
  - Sub-phase 1: PATD = {high half, high half}.
  - PATNXT in sub-phase 0 sets sub-phase 1 without popping.
  - PATNXT in sub-phase 1 pops and returns to sub-phase 0.
- Changing NIBMODE mid-entry resets the sub-phase to 0 on the next edge and pops nothing.
- PATFULL = (count == DEPTH). PATVALID = (count != 0).

## Timing
- Reset values: PATD=0, PATVALID=0, PATFULL=0, PATOVF=0, PATCNT=0, sub-phase 0, pointers 0.
- Reset mid-operation: all state clears immediately and asynchronously. The first load is accepted on the first rising edge after RESETL deasserts.
- Load latency: a push at edge k makes PATVALID, PATCNT and PATD (if previously empty) reflect the new state after edge k.
- Advance latency: a pop or sub-phase change at edge k presents the next head or half on PATD after edge k. There is no bubble, so one pixel per clock is sustained.
- Flags: PATFULL, PATOVF and PATCNT are registered and update on the same edge as the causing event.
- Throughput: one push and one pop per clock.

## Configuration
- PATDATA_NIBBLE_EN defined: NIBMODE port, sub-phase register and half-replication mux are compiled in.
- PATDATA_NIBBLE_EN undefined: NIBMODE is absent and word mode is the only behaviour. Every valid PATNXT pops.

## Test plan
- Reset then idle: RESETL low mid-run, with prior PATCNT=3 and PATD=8'h5A -> all outputs 0 immediately; 8'h11 loaded next cycle appears on PATD one edge later.
- Fill and overflow (DEPTH=4): push 8'h01..8'h04 -> PATFULL=1, PATCNT=4. Fifth push of 8'hFF -> PATOVF=1, PATCNT=4. Pops then yield 01,02,03,04 in order; PATD holds 04 once empty.
- Simultaneous push/pop while full: push 8'hAA with PATNXT=1 -> PATCNT stays 4, PATOVF stays 0. 8'hAA emerges after the four earlier entries.
- Flush priority: CLRPAT=1 with LDPATL=0 and PATNXT=1 in the same cycle -> PATCNT=0, PATOVF=0, PATVALID=0, no push.
- Nibble mode (macro on, NIBMODE=1): push 8'h3C -> PATD=8'hCC. PATNXT -> PATD=8'h33 with PATCNT still 1. PATNXT -> PATCNT=0.
- Wrap-around: 10 interleaved push/pop cycles with DEPTH=4 and data 0..9 -> output order 0..9, PATCNT never exceeds 2.
